// File: rtl/digit_scanner_pkg.sv
// rtl/digit_scanner_pkg.sv - shared constants and digit-to-code helper for the hex digit scanner
package digit_scanner_pkg;

    localparam int          NUM_DIGITS      = 4;
    localparam logic [3:0]  BLANK_CODE      = 4'h0;
    localparam logic [3:0]  CODE_OFFSET     = 4'h1;
    localparam int          DEFAULT_CLK_DIV = 50000;

    // Code 0 is reserved for a dark digit, so visible digits are shifted up by one
    // and the top digit value (F) has no code of its own.
    function automatic logic [3:0] digit_code(input logic [3:0] digit);
        if (digit == 4'hF) begin
            return BLANK_CODE;
        end
        return digit + CODE_OFFSET;
    endfunction

endpackage

// File: rtl/digit_scanner_prescaler.sv
// rtl/digit_scanner_prescaler.sv - digit_prescaler: counts 0..CLK_DIV-1 and flags the last count
module digit_prescaler
    import digit_scanner_pkg::*;
#(
    parameter int CLK_DIV = DEFAULT_CLK_DIV
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int               CW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0]    LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (count == LAST) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    assign tick = (count == LAST);

endmodule

// File: rtl/digit_scanner.sv
// rtl/digit_scanner.sv - four-digit multiplexed display scanner with frame-aligned value commit (option: LEADING_ZERO_BLANK_EN)
module digit_scanner
    import digit_scanner_pkg::*;
#(
    parameter int CLK_DIV = DEFAULT_CLK_DIV
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [15:0] value,
    input  logic        blank,
    output logic [3:0]  code,
    output logic [3:0]  anode,
    output logic        ready,
    output logic        frame_done
);

    localparam logic [1:0] LAST_INDEX = 2'(NUM_DIGITS - 1);

    logic        tick;
    logic        wrap;
    logic [1:0]  index;
    logic [15:0] active;
    logic [15:0] shadow;
    logic        pending;
    logic [3:0]  cur_digit;
    logic        suppress;

    digit_prescaler #(
        .CLK_DIV (CLK_DIV)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .tick (tick)
    );

    assign wrap = tick && (index == LAST_INDEX);

    // active only ever changes on a wrap, so a frame is always drawn from one value
    always_ff @(posedge clk) begin
        if (rst) begin
            index   <= 2'd0;
            active  <= 16'h0000;
            shadow  <= 16'h0000;
            pending <= 1'b0;
        end else begin
            if (tick) begin
                index <= index + 2'd1;
            end
            if (load) begin
                shadow <= value;
            end
            if (wrap) begin
                if (load) begin
                    active <= value;
                end else if (pending) begin
                    active <= shadow;
                end
                pending <= 1'b0;
            end else if (load) begin
                pending <= 1'b1;
            end
        end
    end

    assign ready      = ~pending;
    assign frame_done = wrap;
    assign cur_digit  = active[{index, 2'b00} +: 4];

`ifdef LEADING_ZERO_BLANK_EN
    // A digit is dark when it and every more significant digit are zero; digit 0 always shows.
    assign suppress = (index != 2'd0) && ((active >> {index, 2'b00}) == 16'h0000);
`else
    assign suppress = 1'b0;
`endif

    always_comb begin
        code  = BLANK_CODE;
        anode = 4'b1111;
        if (!blank) begin
            anode = ~(4'b0001 << index);
            if (!suppress) begin
                code = digit_code(cur_digit);
            end
        end
    end

endmodule

// File: doc/digit_scanner.md
DIGIT_SCANNER -- requirements
Module: digit_scanner

Interface
REQ-001 Parameter: CLK_DIV, default 50000, clk cycles per digit slot (minimum 2).
REQ-002 clk  input  1  single clock; every register updates on its rising edge.
REQ-003 rst  input  1  reset; synchronous, active-high.
REQ-004 load  input  1  one-cycle request to capture value; accepted on any cycle.
REQ-005 value  input  16  four hex digits; digit n = value[4n+3:4n], digit 0 least significant.
REQ-006 blank  input  1  display blanking; scanning continues while high.
REQ-007 code  output  4  display code to the downstream 7-segment encoder.
REQ-008 anode  output  4  digit select, active-low, one-hot-zero.
REQ-009 ready  output  1  high when no captured value is waiting for commit.
REQ-010 frame_done  output  1  one-cycle pulse at each frame wrap.

Function
REQ-011 The prescaler shall count 0..CLK_DIV-1 and raise an internal tick in the cycle it equals CLK_DIV-1, then return to 0.
REQ-012 On tick, the digit index shall advance 0->1->2->3->0; each digit is held for exactly CLK_DIV cycles.
REQ-013 On the tick where the index wraps 3->0, frame_done shall be 1 for that cycle only.
REQ-014 anode shall drive bit[index] low and all other bits high; with blank=1 it shall be 4'b1111.
REQ-015 Code mapping: digit value v in 0..E -> code v+1; v=F -> code 0 (blank); blank=1 -> code 0.
REQ-016 code and anode shall depend only on registered state and blank; there is no combinational path from load or value.
REQ-017 On load, value shall be written into a shadow register, pending shall be set and ready shall go low on the next cycle.
REQ-018 At a frame wrap with pending=1, the shadow shall be copied into the active register and pending shall clear; the new digits take effect from digit 0 of the new frame.
REQ-019 A load in the same cycle as a frame wrap shall commit value directly to active at that wrap; pending shall end at 0.
REQ-020 Multiple loads within one frame: the last one shall win; earlier ones are discarded.
REQ-021 The active digits shall never change mid-frame; a frame never shows a mix of old and new digits.

Reset
REQ-022 With rst high at a clock edge, the following shall hold: prescaler=0, index=0, active=0, shadow=0, pending=0.
REQ-023 The resulting outputs shall be: ready=1, frame_done=0, anode=4'b1110 (if blank=0), code=1.
REQ-024 rst overrides load, tick and any in-flight commit; an uncommitted shadow is lost.

Configuration
REQ-025 Macro LEADING_ZERO_BLANK_EN.
- Defined: digits above the most significant non-zero digit shall output code 0; digit 0 is always shown.
- Undefined: all four digits are shown per REQ-015.

Structure
REQ-026 A shared package shall hold:
- the digit-count constant (4);
- the blank code constant (4'h0);
- the display-code offset (1);
- the default CLK_DIV.
REQ-027 Sub-module: digit_prescaler, the CLK_DIV counter with tick output. All other logic stays inline.

Verification (CLK_DIV=4)
REQ-028 Reset release, blank=0 -> anode 1110,1101,1011,0111, each held 4 cycles; frame_done every 16 cycles; all codes =1.
REQ-029 load 16'h1A3F mid-frame.
- Until the wrap: ready=0 and displayed digits are unchanged.
- Next frame: digit0 code 0, digit1 code 4, digit2 code B, digit3 code 2; ready=1.
REQ-030 load 16'h2222 coincident with frame_done -> next frame all codes 3; ready stays 1.
REQ-031 Two loads in one frame (16'h1111 then 16'h4444) -> next frame all codes 5.
REQ-032 LEADING_ZERO_BLANK_EN defined.
- value 16'h0050 -> digit3 and digit2 code 0, digit1 code 6, digit0 code 1.
- value 16'h0000 -> only digit0 code 1.
REQ-033 rst mid-frame with a pending load.
- Next cycle: reset values of REQ-023; pending cleared.
- blank=1 at any point: anode=1111 and code=0 while the index keeps advancing.
